// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM state encoding shared by the multi-cycle ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_NOT  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_NEG  = 4'd5,
    OP_MUL  = 4'd6,
    OP_DIV  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SHRA = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/alu_comb_unit.sv
// alu_comb_unit: single-cycle logic, add/sub/neg, shift and rotate operations
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0] sh, nsh;
  assign sh  = b[SHW-1:0];
  // complementary amount modulo WIDTH; a zero shift makes both halves equal a
  assign nsh = ~sh + 1'b1;
  always_comb
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_NEG:  y = -a;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SHRA: y = $signed(a) >>> sh;
      OP_ROL:  y = (a << sh) | (a >> nsh);
      OP_ROR:  y = (a >> sh) | (a << nsh);
      default: y = '0;
    endcase
endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with Booth multiply and non-restoring signed divide
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] ALU_result,
  output logic               div_zero
);
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);
  state_t state, state_nx;
  logic [SHW:0] cnt;
  logic [WIDTH:0] acc, mx, b_sum, b_acc, r_sh, r_nx;
  logic [WIDTH-1:0] q, m, b_q, q_nx, rem, quo, abs_a, abs_b, comb_y;
  logic q_1, b_q1, neg_q, neg_r, last, accept;
  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .op(opcode),
    .a (input_a),
    .b (input_b),
    .y (comb_y)
  );
  assign last   = cnt == LAST;
  assign accept = state == S_IDLE && start;
  assign abs_a  = input_a[WIDTH-1] ? -input_a : input_a;
  assign abs_b  = input_b[WIDTH-1] ? -input_b : input_b;
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    case (state)
      S_IDLE:       state_nx = !start ? S_IDLE : opcode == OP_MUL ? S_MUL :
                               (opcode == OP_DIV && input_b != '0) ? S_DIV : S_DONE;
      S_MUL, S_DIV: state_nx = last ? S_DONE : state;
      default:      state_nx = S_IDLE;
    endcase
  always_comb begin
    busy = state == S_MUL || state == S_DIV;
    done = state == S_DONE;
  end
  // Booth step: add/sub multiplicand by {q[0], q_1}, then arithmetic shift {acc, q, q_1}
  always_comb begin
    mx = {m[WIDTH-1], m};
    b_sum = (q[0] && !q_1) ? acc - mx : (!q[0] && q_1) ? acc + mx : acc;
    {b_acc, b_q, b_q1} = {b_sum[WIDTH], b_sum, q};
  end
  // Non-restoring step on magnitudes; signs are applied on the final iteration
  always_comb begin
    r_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    r_nx = acc[WIDTH] ? r_sh + {1'b0, m} : r_sh - {1'b0, m};
    q_nx = {q[WIDTH-2:0], ~r_nx[WIDTH]};
    rem  = r_nx[WIDTH] ? r_nx[WIDTH-1:0] + m : r_nx[WIDTH-1:0];
    quo  = neg_q ? -q_nx : q_nx;
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      cnt        <= '0;
      acc        <= '0;
      q          <= '0;
      m          <= '0;
      q_1        <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      ALU_result <= '0;
      div_zero   <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      acc      <= '0;
      q_1      <= 1'b0;
      q        <= opcode == OP_DIV ? abs_a : input_b;
      m        <= opcode == OP_DIV ? abs_b : input_a;
      neg_q    <= input_a[WIDTH-1] ^ input_b[WIDTH-1];
      neg_r    <= input_a[WIDTH-1];
      div_zero <= opcode == OP_DIV && input_b == '0;
      if (state_nx == S_DONE) ALU_result <= {{WIDTH{1'b0}}, comb_y};
    end else if (state == S_MUL) begin
      cnt <= cnt + 1'b1;
      acc <= b_acc;
      q   <= b_q;
      q_1 <= b_q1;
      if (last) ALU_result <= {b_acc[WIDTH-1:0], b_q};
    end else if (state == S_DIV) begin
      cnt <= cnt + 1'b1;
      acc <= r_nx;
      q   <= q_nx;
      if (last) ALU_result <= {neg_r ? -rem : rem, quo};
    end
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: vector table, directed corner sequences and randomized model checks for mc_alu
module tb_mc_alu;
  logic clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [3:0] opcode = '0;
  logic [31:0] input_a = '0, input_b = '0;
  logic busy, done, div_zero;
  logic [63:0] ALU_result;
  int checks = 0, errors = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .input_a(input_a), .input_b(input_b), .busy(busy), .done(done),
    .ALU_result(ALU_result), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] r;
    logic dz;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int amt;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    amt = int'(b % 32);
    r = '0;
    case (op)
      4'd0: r = a | b;
      4'd1: r = a & b;
      4'd2: r = ~a;
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = 32'd0 - a;
      4'd6: return sa * sb;
      4'd7: return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      4'd8: r = a << amt;
      4'd9: r = a >> amt;
      4'd10: r = 32'(sa >>> amt);
      4'd11: begin r = a; repeat (amt) r = {r[30:0], r[31]}; end
      4'd12: begin r = a; repeat (amt) r = {r[0], r[31:1]}; end
      default: r = '0;
    endcase
    return {32'd0, r};
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_r, input logic exp_dz,
                        input int exp_lat);
    int cyc, nbusy;
    @(negedge clock);
    start = 1'b1; opcode = op; input_a = a; input_b = b;
    @(posedge clock); #1;
    start = 1'b0; opcode = 4'($urandom); input_a = $urandom; input_b = $urandom;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 100) begin
      nbusy += int'(busy);
      @(posedge clock); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check({name, " result"}, ALU_result, exp_r);
    check({name, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check({name, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    @(posedge clock); #1;
    check({name, " done pulse"}, 64'(done), 64'd0);
    check({name, " held"}, ALU_result, exp_r);
  endtask

  vec_t vt[$];

  initial begin
    int cyc, ndone;
    logic [3:0] op;
    logic [31:0] a, b;
    vt.push_back('{"add", 4'd3, 32'd20, 32'd5, 64'd25, 1'b0, 1});
    vt.push_back('{"mul", 4'd6, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 33});
    vt.push_back('{"div", 4'd7, 32'hFFFF_FFEC, 32'd6, {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0, 33});
    vt.push_back('{"div0", 4'd7, 32'hFFFF_FFEC, 32'd0, 64'd0, 1'b1, 1});
    vt.push_back('{"rol", 4'd11, 32'h8000_0001, 32'd4, 64'h18, 1'b0, 1});
    vt.push_back('{"shra", 4'd10, 32'h8000_0000, 32'd4, 64'hF800_0000, 1'b0, 1});
    vt.push_back('{"shl36", 4'd8, 32'h0000_0001, 32'd36, 64'h10, 1'b0, 1});
    vt.push_back('{"divmin", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33});
    vt.push_back('{"ror", 4'd12, 32'h0000_0001, 32'd1, 64'h8000_0000, 1'b0, 1});
    vt.push_back('{"neg", 4'd5, 32'h0000_0001, 32'd9, 64'hFFFF_FFFF, 1'b0, 1});
    vt.push_back('{"sub", 4'd4, 32'd0, 32'd1, 64'hFFFF_FFFF, 1'b0, 1});
    vt.push_back('{"op13", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1});
    vt.push_back('{"mulmin", 4'd6, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33});
    vt.push_back('{"div7m2", 4'd7, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 33});
    vt.push_back('{"or", 4'd0, 32'hF0F0_0000, 32'h0000_0F0F, 64'hF0F0_0F0F, 1'b0, 1});

    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", ALU_result, 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock) clear = 1'b0;

    foreach (vt[i]) run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].dz, vt[i].lat);

    // second start during a MUL must be dropped
    @(negedge clock);
    start = 1'b1; opcode = 4'd6; input_a = 32'hFFFF_FFF9; input_b = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    repeat (4) begin @(posedge clock); #1; cyc++; end
    @(negedge clock);
    start = 1'b1; opcode = 4'd3; input_a = 32'd1; input_b = 32'd1;
    @(posedge clock); #1;
    cyc++;
    start = 1'b0;
    check("gate busy", 64'(busy), 64'd1);
    while (!done && cyc < 100) begin @(posedge clock); #1; cyc++; end
    check("gate latency", 64'(cyc), 64'd33);
    check("gate result", ALU_result, 64'hFFFF_FFFF_FFFF_FFD6);
    @(posedge clock); #1;
    check("gate no requeue", 64'(done), 64'd0);

    // clear in the middle of a DIV, with start held high during clear
    run_op("pre", 4'd3, 32'd20, 32'd5, 64'd25, 1'b0, 1);
    @(negedge clock);
    start = 1'b1; opcode = 4'd7; input_a = 32'd100; input_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    clear = 1'b1;
    start = 1'b1; opcode = 4'd3; input_a = 32'd3; input_b = 32'd4;
    #1;
    check("clr busy", 64'(busy), 64'd0);
    check("clr done", 64'(done), 64'd0);
    check("clr result", ALU_result, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    check("clr start blocked", 64'(done), 64'd0);
    @(negedge clock);
    clear = 1'b0; start = 1'b0;
    ndone = 0;
    repeat (40) begin @(posedge clock); #1; ndone += int'(done); end
    check("clr no done", 64'(ndone), 64'd0);
    check("clr result stays", ALU_result, 64'd0);
    run_op("post clr add", 4'd3, 32'd3, 32'd4, 64'd7, 1'b0, 1);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 8 == 0) ? 32'd0 : (i % 8 == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 16 == 2) begin op = 4'd7; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, model(op, a, b),
             op == 4'd7 && b == 0, (op == 4'd6 || (op == 4'd7 && b != 0)) ? 33 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are powers of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 SHALL have port clear  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port opcode  input  4  operation select, sampled with start.
REQ-007 SHALL have port input_a  input  WIDTH  operand A, sampled with start.
REQ-008 SHALL have port input_b  input  WIDTH  operand B, sampled with start.
REQ-009 SHALL have port busy  output  1  high while a MUL or DIV is iterating.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result is valid on the same cycle.
REQ-011 SHALL have port ALU_result  output  2*WIDTH  registered result, held until the next accepted start.
REQ-012 SHALL have port div_zero  output  1  set by DIV with B=0; cleared by the next accepted start.

Function
REQ-013 SHALL use the opcode map 0 OR, 1 AND, 2 NOT, 3 ADD, 4 SUB, 5 NEG, 6 MUL, 7 DIV, 8 SHL, 9 SHR, 10 SHRA, 11 ROL, 12 ROR; opcodes 13..15 SHALL yield result 0.
REQ-014 SHALL use states IDLE, MUL, DIV and DONE.
REQ-015 SHALL, on start in IDLE, latch opcode and operands, clear div_zero and select the next state: MUL for opcode 6, DIV for opcode 7 with B≠0, DONE otherwise.
REQ-016 SHALL compute single-cycle ops (0-5, 8-12) in a 1-cycle latency: start at edge k -> done=1 during cycle k+1.
REQ-017 SHALL zero-extend single-cycle results into ALU_result[2W-1:0], upper W bits 0; ADD, SUB and NEG SHALL wrap modulo 2^WIDTH with no carry or overflow output.
REQ-018 SHALL use only B[SHW-1:0] as the shift/rotate amount; SHRA SHALL replicate A[W-1]; ROL and ROR SHALL rotate within WIDTH bits.
REQ-019 SHALL implement MUL as a signed radix-2 Booth multiply with one iteration per cycle and WIDTH iterations; busy=1 for exactly WIDTH cycles, then DONE; start at k -> done at cycle k+WIDTH+1.
REQ-020 SHALL place the full signed 2W-bit MUL product on ALU_result.
REQ-021 SHALL implement DIV as signed non-restoring division with WIDTH iterations and the same timing as MUL.
REQ-022 SHALL give a DIV result of ALU_result = {remainder, quotient}, with the quotient truncated toward zero and the remainder carrying the sign of the dividend.
REQ-023 SHALL handle DIV with B=0 without iterating: go to DONE, done at k+1, ALU_result=0, div_zero=1.
REQ-024 SHALL handle DIV of -2^(W-1) by -1 as quotient -2^(W-1), remainder 0, with no flag.
REQ-025 SHALL, in DONE, assert done for one cycle and return to IDLE; busy SHALL be 0 in IDLE and DONE.
REQ-026 SHALL ignore start in MUL, DIV and DONE, with no queuing; back-to-back start is accepted on the cycle after done.
REQ-027 SHALL leave ALU_result unchanged while iterating and update it only on the edge entering DONE.
REQ-028 SHALL ignore operand and opcode changes after acceptance.

Reset
REQ-029 SHALL on clear=1, asynchronously and at any state including mid-MUL/DIV, force state to IDLE and busy, done, div_zero and ALU_result to 0, and reset the iteration counter and accumulators.
REQ-030 SHALL accept no start while clear=1; the first start is accepted on the first edge after clear falls.

Structure
REQ-031 SHALL take the opcode constants, the state encoding and the opcode enum typedef from shared package alu_pkg.
REQ-032 SHALL place single-cycle logic (logic, add/sub/neg, shifts, rotates) in one combinational sub-module alu_comb_unit #(WIDTH).
REQ-033 SHALL keep the FSM, iteration counter (SHW+1 bits) and Booth/division datapath in mc_alu.

Verification
REQ-034 SHALL verify ADD, with WIDTH=32: A=20, B=5, opcode 3, start at k -> done at k+1, ALU_result=25, busy never high.
REQ-035 SHALL verify MUL: A=-7, B=6 -> busy for 32 cycles, done at k+33, ALU_result=64'hFFFF_FFFF_FFFF_FFD6.
REQ-036 SHALL verify DIV and divide-by-zero: A=-20, B=6 -> done at k+33, ALU_result={32'hFFFF_FFFE, 32'hFFFF_FFFD}; then B=0 -> done at k+1, ALU_result=0, div_zero=1.
REQ-037 SHALL verify shifts: A=32'h8000_0001, B=4, ROL -> 32'h0000_0018; A=32'h8000_0000, SHRA by 4 -> 32'hF800_0000; B=36 for SHL behaves as shift by 4.
REQ-038 SHALL verify start gating: a second start (ADD) asserted at k+5 during a MUL -> ignored, and the MUL result is unchanged at k+33.
REQ-039 SHALL verify clear mid-op: clear asserted at k+10 of a DIV -> busy, done and ALU_result go to 0 immediately, with no done pulse afterward; a new ADD after release completes in 1 cycle.
